// File: rtl/cpu_dp_if.sv
// Control bundle from cpu_ctrl into the execution datapath, plus the
// flag/accumulator observation outputs flowing back.
interface cpu_dp_if #(
    parameter int DWIDTH         = 8,
    parameter int AWIDTH         = 8,
    parameter int ALU_OP_WIDTH   = 4,
    parameter int REG_F_SEL_SIZE = 4,
    parameter int IN_B_SEL_SIZE  = 2
) ();
    logic [ALU_OP_WIDTH-1:0]   ALU_OP;
    logic [DWIDTH-1:0]         IMM;
    logic [IN_B_SEL_SIZE-1:0]  IN_B_SEL;
    logic [REG_F_SEL_SIZE-1:0] REG_F_SEL;
    logic                      EN_REG_F;
    logic [AWIDTH-1:0]         D_MEM_ADDR;
    logic                      D_MEM_ADDR_MODE;
    logic                      EN_D_MEM;
    logic                      EN_ACC;
    logic                      Z;
    logic                      C;
    logic [DWIDTH-1:0]         ACC_OUT;

    // Controller side: drives the decoded instruction, observes flags
    modport master (
        output ALU_OP, IMM, IN_B_SEL, REG_F_SEL, EN_REG_F,
               D_MEM_ADDR, D_MEM_ADDR_MODE, EN_D_MEM, EN_ACC,
        input  Z, C, ACC_OUT
    );

    // Datapath side
    modport slave (
        input  ALU_OP, IMM, IN_B_SEL, REG_F_SEL, EN_REG_F,
               D_MEM_ADDR, D_MEM_ADDR_MODE, EN_D_MEM, EN_ACC,
        output Z, C, ACC_OUT
    );
endinterface

// File: rtl/cpu_dp.sv
// Single-cycle execution datapath: accumulator, 16-entry register file,
// data memory with direct/indirect addressing, ALU and Z/C flags.
module cpu_dp #(
    parameter int DWIDTH         = 8,
    parameter int AWIDTH         = 8,
    parameter int ALU_OP_WIDTH   = 4,
    parameter int REG_F_SEL_SIZE = 4,
    parameter int IN_B_SEL_SIZE  = 2
) (
    input  logic     CLK,
    input  logic     RST,
    cpu_dp_if.slave  bus
);
    localparam int NREG  = 1 << REG_F_SEL_SIZE;
    localparam int DEPTH = 1 << AWIDTH;

    localparam logic [ALU_OP_WIDTH-1:0] OP_NOP = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] OP_LD  = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] OP_ADD = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SUB = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] OP_AND = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] OP_OR  = ALU_OP_WIDTH'(5);
    localparam logic [ALU_OP_WIDTH-1:0] OP_XOR = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] OP_NOT = ALU_OP_WIDTH'(7);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SHL = ALU_OP_WIDTH'(8);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SHR = ALU_OP_WIDTH'(9);
    localparam logic [ALU_OP_WIDTH-1:0] OP_ROL = ALU_OP_WIDTH'(10);
    localparam logic [ALU_OP_WIDTH-1:0] OP_ROR = ALU_OP_WIDTH'(11);
    localparam logic [ALU_OP_WIDTH-1:0] OP_INC = ALU_OP_WIDTH'(12);
    localparam logic [ALU_OP_WIDTH-1:0] OP_DEC = ALU_OP_WIDTH'(13);
    localparam logic [ALU_OP_WIDTH-1:0] OP_CMP = ALU_OP_WIDTH'(14);
    localparam logic [ALU_OP_WIDTH-1:0] OP_ADC = ALU_OP_WIDTH'(15);

    logic [DWIDTH-1:0] acc_q, acc_d;
    logic              z_q, z_d;
    logic              c_q, c_d;
    logic [DWIDTH-1:0] regf_q [NREG];
    logic [DWIDTH-1:0] regf_d [NREG];
    logic [DWIDTH-1:0] dmem_q [DEPTH];

    logic [DWIDTH-1:0] regf_rd;
    logic [AWIDTH-1:0] ea;
    logic [DWIDTH-1:0] dmem_rd;
    logic [DWIDTH-1:0] op_b;
    logic [DWIDTH-1:0] alu_r;
    logic              alu_c;
    logic [DWIDTH:0]   a_x, b_x, ext;

    assign regf_rd = regf_q[bus.REG_F_SEL];

    // Effective address; indirect offset wraps naturally at AWIDTH bits
    always_comb begin
        ea = bus.D_MEM_ADDR;
        if (bus.D_MEM_ADDR_MODE) begin
            ea = AWIDTH'(regf_rd) + bus.D_MEM_ADDR;
        end
    end

    // Asynchronous memory read so LD from memory completes in one cycle
    assign dmem_rd = dmem_q[ea];

    // Operand-B source mux
    always_comb begin
        op_b = '0;
        case (bus.IN_B_SEL)
            IN_B_SEL_SIZE'(0): op_b = bus.IMM;
            IN_B_SEL_SIZE'(1): op_b = regf_rd;
            IN_B_SEL_SIZE'(2): op_b = dmem_rd;
            default:           op_b = '0;
        endcase
    end

    // ALU: result and candidate carry; logic ops leave carry untouched
    always_comb begin
        a_x   = {1'b0, acc_q};
        b_x   = {1'b0, op_b};
        ext   = '0;
        alu_r = acc_q;
        alu_c = c_q;
        case (bus.ALU_OP)
            OP_NOP: alu_r = acc_q;
            OP_LD:  alu_r = op_b;
            OP_ADD: begin
                ext   = a_x + b_x;
                alu_r = ext[DWIDTH-1:0];
                alu_c = ext[DWIDTH];
            end
            OP_SUB, OP_CMP: begin
                // Top bit of the extended difference is the borrow
                ext   = a_x - b_x;
                alu_r = ext[DWIDTH-1:0];
                alu_c = ext[DWIDTH];
            end
            OP_AND: alu_r = acc_q & op_b;
            OP_OR:  alu_r = acc_q | op_b;
            OP_XOR: alu_r = acc_q ^ op_b;
            OP_NOT: alu_r = ~acc_q;
            OP_SHL: begin
                alu_r = {acc_q[DWIDTH-2:0], 1'b0};
                alu_c = acc_q[DWIDTH-1];
            end
            OP_SHR: begin
                alu_r = {1'b0, acc_q[DWIDTH-1:1]};
                alu_c = acc_q[0];
            end
            OP_ROL: begin
                alu_r = {acc_q[DWIDTH-2:0], acc_q[DWIDTH-1]};
                alu_c = acc_q[DWIDTH-1];
            end
            OP_ROR: begin
                alu_r = {acc_q[0], acc_q[DWIDTH-1:1]};
                alu_c = acc_q[0];
            end
            OP_INC: begin
                ext   = a_x + (DWIDTH+1)'(1);
                alu_r = ext[DWIDTH-1:0];
                alu_c = ext[DWIDTH];
            end
            OP_DEC: begin
                ext   = a_x - (DWIDTH+1)'(1);
                alu_r = ext[DWIDTH-1:0];
                alu_c = ext[DWIDTH];
            end
            OP_ADC: begin
                ext   = a_x + b_x + {{DWIDTH{1'b0}}, c_q};
                alu_r = ext[DWIDTH-1:0];
                alu_c = ext[DWIDTH];
            end
            default: alu_r = acc_q;
        endcase
    end

    // Accumulator and flag next-state; CMP updates flags only
    always_comb begin
        acc_d = acc_q;
        z_d   = z_q;
        c_d   = c_q;
        if (bus.EN_ACC) begin
            if (bus.ALU_OP != OP_CMP) begin
                acc_d = alu_r;
            end
            z_d = (alu_r == '0);
            c_d = alu_c;
        end
    end

    // Register file next-state: selected entry captures the pre-edge ACC
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_regf
            always_comb begin
                regf_d[gi] = regf_q[gi];
                if (bus.EN_REG_F && (bus.REG_F_SEL == REG_F_SEL_SIZE'(gi))) begin
                    regf_d[gi] = acc_q;
                end
            end
        end
    endgenerate

    // Architectural state; reset wins over every enable
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q <= '0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regf_q[i] <= '0;
            end
        end else begin
            acc_q <= acc_d;
            z_q   <= z_d;
            c_q   <= c_d;
            for (int i = 0; i < NREG; i++) begin
                regf_q[i] <= regf_d[i];
            end
        end
    end

    // Data memory write; contents survive reset but no write on a reset edge
    always_ff @(posedge CLK) begin
        if (!RST && bus.EN_D_MEM) begin
            dmem_q[ea] <= acc_q;
        end
    end

    assign bus.Z       = z_q;
    assign bus.C       = c_q;
    assign bus.ACC_OUT = acc_q;
endmodule

// File: tb/tb_cpu_dp.sv
// Directed and randomized checks of cpu_dp against an arithmetic reference model.
module tb_cpu_dp;
    logic CLK = 1'b0;
    logic RST;

    cpu_dp_if bus ();

    cpu_dp dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference state
    int m_acc, m_z, m_c;
    int m_rf  [16];
    int m_mem [256];

    localparam int NOP = 0, LD = 1, ADD = 2, SUB = 3, AND_ = 4, OR_ = 5, XOR_ = 6,
                   NOT_ = 7, SHL = 8, SHR = 9, ROL = 10, ROR = 11, INC = 12,
                   DEC = 13, CMP = 14, ADC = 15;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One instruction worth of architectural effect, using plain arithmetic
    task automatic model_apply(input int op, input int imm, input int bsel, input int rsel,
                               input int en_rf, input int addr, input int mode,
                               input int en_dm, input int en_acc, input int rst);
        int a, b, ea, r, cn, t;
        if (rst != 0) begin
            m_acc = 0; m_z = 0; m_c = 0;
            for (int i = 0; i < 16; i++) m_rf[i] = 0;
            return;
        end
        a  = m_acc;
        ea = (mode != 0) ? (m_rf[rsel] + addr) % 256 : addr;
        case (bsel)
            0: b = imm;
            1: b = m_rf[rsel];
            2: b = m_mem[ea];
            default: b = 0;
        endcase
        cn = m_c;
        r  = a;
        case (op)
            NOP:  r = a;
            LD:   r = b;
            ADD:  begin t = a + b; r = t % 256; cn = (t > 255) ? 1 : 0; end
            SUB, CMP: begin r = (a - b + 256) % 256; cn = (a < b) ? 1 : 0; end
            AND_: r = a & b;
            OR_:  r = a | b;
            XOR_: r = a ^ b;
            NOT_: r = 255 - a;
            SHL:  begin r = (a * 2) % 256; cn = a / 128; end
            SHR:  begin r = a / 2; cn = a % 2; end
            ROL:  begin r = (a * 2) % 256 + a / 128; cn = a / 128; end
            ROR:  begin r = a / 2 + (a % 2) * 128; cn = a % 2; end
            INC:  begin t = a + 1; r = t % 256; cn = (t > 255) ? 1 : 0; end
            DEC:  begin r = (a + 255) % 256; cn = (a == 0) ? 1 : 0; end
            ADC:  begin t = a + b + m_c; r = t % 256; cn = (t > 255) ? 1 : 0; end
            default: r = a;
        endcase
        if (en_dm != 0) m_mem[ea] = a;
        if (en_rf != 0) m_rf[rsel] = a;
        if (en_acc != 0) begin
            if (op != CMP) m_acc = r;
            m_z = (r == 0) ? 1 : 0;
            m_c = cn;
        end
    endtask

    // Drive one instruction, clock it, compare against the model
    task automatic step(input string tag, input int op, input int imm, input int bsel,
                        input int rsel, input int en_rf, input int addr, input int mode,
                        input int en_dm, input int en_acc, input int rst);
        bus.ALU_OP          = 4'(op);
        bus.IMM             = 8'(imm);
        bus.IN_B_SEL        = 2'(bsel);
        bus.REG_F_SEL       = 4'(rsel);
        bus.EN_REG_F        = 1'(en_rf);
        bus.D_MEM_ADDR      = 8'(addr);
        bus.D_MEM_ADDR_MODE = 1'(mode);
        bus.EN_D_MEM        = 1'(en_dm);
        bus.EN_ACC          = 1'(en_acc);
        RST                 = 1'(rst);
        model_apply(op, imm, bsel, rsel, en_rf, addr, mode, en_dm, en_acc, rst);
        @(posedge CLK);
        #1;
        $display("step %s op=%0d imm=%02h acc=%02h z=%0b c=%0b", tag, op, imm,
                 bus.ACC_OUT, bus.Z, bus.C);
        chk({tag, ".acc"}, 32'(bus.ACC_OUT), 32'(m_acc));
        chk({tag, ".z"},   32'(bus.Z),       32'(m_z));
        chk({tag, ".c"},   32'(bus.C),       32'(m_c));
    endtask

    // Shorthands
    task automatic alu(input string tag, input int op, input int imm);
        step(tag, op, imm, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        int op, rs, rst;
        bus.ALU_OP = '0; bus.IMM = '0; bus.IN_B_SEL = '0; bus.REG_F_SEL = '0;
        bus.EN_REG_F = 1'b0; bus.D_MEM_ADDR = '0; bus.D_MEM_ADDR_MODE = 1'b0;
        bus.EN_D_MEM = 1'b0; bus.EN_ACC = 1'b0;
        RST = 1'b1;
        m_acc = 0; m_z = 0; m_c = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = 0;

        // Reset state
        step("reset", NOP, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("reset.acc0", 32'(bus.ACC_OUT), 32'h0);
        for (int r = 0; r < 16; r++) begin
            step("rf_zero", LD, 0, 1, r, 0, 0, 0, 0, 1, 0);
            chk("rf_zero.const", 32'(bus.ACC_OUT), 32'h0);
        end

        // Fill memory with known values: each cycle stores old ACC, loads new
        for (int i = 0; i < 256; i++)
            step("fill", LD, $urandom_range(0, 255), 0, 0, 0, i, 0, 1, 1, 0);

        // Memory retained across reset
        alu("pre33", LD, 8'h33);
        step("st5", NOP, 0, 0, 0, 0, 5, 0, 1, 0, 0);
        step("rst2", NOP, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("ld5", LD, 0, 2, 0, 0, 5, 0, 0, 1, 0);
        chk("mem_keep", 32'(bus.ACC_OUT), 32'h33);

        // Immediate arithmetic
        alu("ldf0", LD, 8'hF0);
        alu("add20", ADD, 8'h20);
        chk("add.acc", 32'(bus.ACC_OUT), 32'h10);
        chk("add.c", 32'(bus.C), 32'h1);
        chk("add.z", 32'(bus.Z), 32'h0);
        alu("sub10", SUB, 8'h10);
        chk("sub.acc", 32'(bus.ACC_OUT), 32'h00);
        chk("sub.z", 32'(bus.Z), 32'h1);
        chk("sub.c", 32'(bus.C), 32'h0);

        // Store old ACC while loading a new one
        alu("ld5a", LD, 8'h5A);
        step("swap", LD, 8'h01, 0, 3, 1, 0, 0, 0, 1, 0);
        chk("swap.acc", 32'(bus.ACC_OUT), 32'h01);
        step("rd_r3", LD, 0, 1, 3, 0, 0, 0, 0, 1, 0);
        chk("swap.rf3", 32'(bus.ACC_OUT), 32'h5A);

        // Indirect addressing with wrap
        alu("ldfe", LD, 8'hFE);
        step("st_r2", NOP, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        alu("ld77", LD, 8'h77);
        step("ind_st", NOP, 0, 0, 2, 0, 3, 1, 1, 0, 0);
        alu("clr", LD, 8'h00);
        step("ind_ld", LD, 0, 2, 2, 0, 3, 1, 0, 1, 0);
        chk("ind.acc", 32'(bus.ACC_OUT), 32'h77);
        alu("clr2", LD, 8'h00);
        step("dir_ld1", LD, 0, 2, 0, 0, 1, 0, 0, 1, 0);
        chk("wrap.mem1", 32'(bus.ACC_OUT), 32'h77);

        // CMP leaves ACC, then flags held when EN_ACC=0
        alu("ld40", LD, 8'h40);
        alu("cmp40", CMP, 8'h40);
        chk("cmp.acc", 32'(bus.ACC_OUT), 32'h40);
        chk("cmp.z", 32'(bus.Z), 32'h1);
        step("hold", INC, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("hold.acc", 32'(bus.ACC_OUT), 32'h40);
        chk("hold.z", 32'(bus.Z), 32'h1);

        // Rotate into carry then ADC consumes it
        alu("ld81", LD, 8'h81);
        alu("rol", ROL, 0);
        chk("rol.acc", 32'(bus.ACC_OUT), 32'h03);
        chk("rol.c", 32'(bus.C), 32'h1);
        alu("adc0", ADC, 8'h00);
        chk("adc.acc", 32'(bus.ACC_OUT), 32'h04);
        chk("adc.c", 32'(bus.C), 32'h0);

        // Reset during a store: no write, ACC cleared
        alu("ld99", LD, 8'h99);
        step("rst_st", NOP, 0, 0, 0, 0, 8'h10, 0, 1, 1, 1);
        chk("rst_st.acc", 32'(bus.ACC_OUT), 32'h0);
        step("rd10", LD, 0, 2, 0, 0, 8'h10, 0, 0, 1, 0);

        // Same-cycle read and write of one location returns old data
        alu("ldab", LD, 8'hAB);
        step("rw20", LD, 0, 2, 0, 0, 8'h20, 0, 1, 1, 0);
        step("rd20", LD, 0, 2, 0, 0, 8'h20, 0, 0, 1, 0);
        chk("rw20.new", 32'(bus.ACC_OUT), 32'hAB);

        // Randomized instruction stream
        for (int n = 0; n < 600; n++) begin
            op  = $urandom_range(0, 15);
            rs  = $urandom_range(0, 15);
            rst = ($urandom_range(0, 59) == 0) ? 1 : 0;
            step("rand", op, $urandom_range(0, 255), $urandom_range(0, 3), rs,
                 $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 1),
                 $urandom_range(0, 1), ($urandom_range(0, 3) != 0) ? 1 : 0, rst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
